seq_mult_16_bit: RTL
====================

// Module: seq_mult_16_bit
// PURPOSE
//  Unsigned 16x16 -> 32-bit shift-and-add multiplier.
//  - Direct consumer of the 16-bit lookahead-carry adder: one CLA add per iteration.
//  - Sits downstream of that adder in the datapath; it is the first multi-cycle arithmetic unit built on it.
//  - start/busy/done handshake; 16 iterations per product.
// PARAMETERS
//  WIDTH   16  operand width; only 16 is legal (adder is fixed 16-bit)
//  CNT_W   5   iteration counter width; must hold 0..WIDTH
// PORTS
//  clk      in   1   clock, rising edge
//  rst_n    in   1   asynchronous active-low reset
//  start    in   1   request; sampled only in IDLE or DONE
//  a        in   16  multiplicand; captured on accepted start
//  b        in   16  multiplier; captured on accepted start
//  busy     out  1   high while in RUN
//  done     out  1   one-cycle pulse; product valid in that cycle
//  product  out  32  result; held until next accepted start
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
//  Reset: state=IDLE, busy=0, done=0, product=0, internal acc/mcand/cnt=0.
//    - Asserting rst_n low mid-RUN aborts immediately; no done pulse is produced.
//  States:
//    - IDLE: start=1 -> RUN, mcand<=a, acc<={16'h0,b}, cnt<=0.
//    - RUN: each edge, add = acc[31:16] + (acc[0] ? mcand : 0), c_in=0.
//      Then acc <= {c_out, sum, acc[15:1]}, a right shift by 1 with the carry kept.
//      cnt <= cnt+1.
//      When cnt==15 at the edge -> DONE.
//    - DONE: done=1 for exactly one cycle; product=acc.
//      start=1 -> RUN with new operands (back-to-back); otherwise -> IDLE.
//  Latency: start accepted at edge E0.
//    - 16 RUN edges follow (E1..E16).
//    - done=1 during the cycle after E16, i.e. visible after the 17th edge counted from E0.
//    - Back-to-back throughput: one result per 17 cycles.
//  start while busy: ignored; operands are not re-captured.
//  busy=1 exactly in RUN; busy and done are never both high.
//  product register:
//    - Updates only on entry to DONE.
//    - Stable in IDLE and RUN (previous result held; 0 after reset).
//  Arithmetic:
//    - Unsigned only.
//    - The adder's c_out becomes bit 31 of acc before the shift, so no overflow is possible.
//    - Max result 0xFFFE0001.
//  The adder's P/G outputs are unused (left unconnected).
// STRUCTURE
//  Shared package/header:
//    - state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
//    - WIDTH.
//    - LAST_ITER=WIDTH-1.
//  Sub-module: the existing 16-bit lookahead-carry adder, instantiated once.
//    - Connections: .a(acc[31:16]) .b(addend) .c_in(1'b0) .sum .c_out.
//  Remaining logic is one FSM plus acc/mcand/cnt/product registers; the FSM uses separate next-state and output logic.
// TESTING
//  a=16'hFFFF, b=16'hFFFF, start 1 cycle -> done after 17 edges, product=32'hFFFE0001.
//  a=16'd250, b=16'd161 -> product=32'd40250; a=16'h0000, b=16'h1234 -> product=0.
//  a=16'h8000, b=16'd2 -> product=32'h00010000; busy=1 for exactly 16 cycles.
//  Start asserted every cycle during RUN with other operands -> ignored.
//    - The first product is unaffected.
//    - Exactly one done pulse per accepted start.
//  start held high in DONE (a=3, b=5 after a=7, b=9) -> product=63, then product=15 after 17 more cycles.
//  rst_n low at RUN cycle 8 -> busy=0, done=0, product=0 asynchronously.
//    - After release, a fresh start (a=2, b=3) gives product=6.
//  Random: 1000 operand pairs checked against a*b from a reference model.

Source files
------------

// File: rtl/seq_mult_16_bit_pkg.sv
// Shared constants and state encoding for the 16x16 shift-and-add multiplier.
package seq_mult_16_bit_pkg;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned LAST_ITER = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult_16_bit_cla.sv
// 16-bit lookahead-carry adder: four 4-bit lookahead groups plus group propagate/generate.
module seq_mult_16_bit_cla (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out,
  output logic        p,
  output logic        g
);

  logic [15:0] pi, gi;
  logic [16:0] c;
  logic [3:0]  gp, gg;

  always_comb begin
    pi = a ^ b;
    gi = a & b;
    c  = '0;
    gp = '0;
    gg = '0;
    c[0] = c_in;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &pi[4*k +: 4];
      gg[k] = gi[4*k+3]
            | (pi[4*k+3] & gi[4*k+2])
            | (pi[4*k+3] & pi[4*k+2] & gi[4*k+1])
            | (pi[4*k+3] & pi[4*k+2] & pi[4*k+1] & gi[4*k]);
      // Carries inside a group are expanded from the group's carry-in, not rippled.
      c[4*k+1] = gi[4*k] | (pi[4*k] & c[4*k]);
      c[4*k+2] = gi[4*k+1] | (pi[4*k+1] & gi[4*k]) | (pi[4*k+1] & pi[4*k] & c[4*k]);
      c[4*k+3] = gi[4*k+2] | (pi[4*k+2] & gi[4*k+1]) | (pi[4*k+2] & pi[4*k+1] & gi[4*k])
               | (pi[4*k+2] & pi[4*k+1] & pi[4*k] & c[4*k]);
      c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
    end
    sum = pi ^ c[15:0];
    p   = &gp;
    g   = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
    c_out = g | (p & c_in);
  end

endmodule

// File: rtl/seq_mult_16_bit.sv
// Unsigned 16x16 -> 32 shift-and-add multiplier, one CLA add per iteration, start/busy/done.
module seq_mult_16_bit
  import seq_mult_16_bit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 c_out;
  logic                 unused_p, unused_g;

  assign addend = acc_q[0] ? mcand_q : '0;

  seq_mult_16_bit_cla u_cla (
    .a     (acc_q[2*WIDTH-1:WIDTH]),
    .b     (addend),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out),
    .p     (unused_p),
    .g     (unused_g)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          mcand_d = a;
          acc_d   = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Carry-out lands in bit 31 so the shifted accumulator never overflows.
        acc_d = {c_out, sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(LAST_ITER)) begin
          state_d   = S_DONE;
          product_d = acc_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs follow the state being entered.
  always_comb begin
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
